// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised MIPS register file.
// The clear-sweep state encoding and the byte-merge helper live here.
package regfile_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    // One lane of a byte-enabled write: the new byte replaces the old one only when enabled.
    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep sequencer: walks registers 1..DEPTH-1, one per cycle, after a clear request.
// Exposes the register index being zeroed this cycle plus registered busy/done flags.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic [AW-1:0] clr_idx,
    output logic          clr_valid,
    output logic          clr_busy,
    output logic          clr_done
);

    clr_state_t    state, state_next;
    logic [AW-1:0] idx, idx_next;
    logic          done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLR_IDLE;
            idx      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            clr_done <= done_next;
        end
    end

    // Register 0 is hardwired zero, so the sweep starts at 1 and stops after DEPTH-1.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        done_next  = 1'b0;
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_next = CLR_SWEEP;
                    idx_next   = AW'(1);
                end
            end
            CLR_SWEEP: begin
                idx_next = idx + AW'(1);
                if (idx == AW'(DEPTH - 1)) begin
                    state_next = CLR_IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = CLR_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign clr_idx   = idx;
    assign clr_valid = (state == CLR_SWEEP);
    assign clr_busy  = (state == CLR_SWEEP);

endmodule

// File: rtl/regfile_mips_param.sv
// Parametrised MIPS register file: NUM_RD async read ports, two byte-enabled write ports, clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mips_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int NB     = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic [NB-1:0]            wr0_be,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NB-1:0]            wr1_be,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     clr_idx;
    logic              clr_valid;
    logic              wr0_en, wr1_en;
    logic [DATA_W-1:0] wr0_word, wr1_base, wr1_word;

    regfile_clear_fsm #(
        .DEPTH(DEPTH)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req & ~clr_busy),
        .clr_idx  (clr_idx),
        .clr_valid(clr_valid),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    // Port 1 merges on top of port 0's result when both hit the same register, so it wins per byte.
    always_comb begin
        wr0_en   = (wr0_be != '0) && (wr0_addr != '0) && !clr_busy;
        wr1_en   = (wr1_be != '0) && (wr1_addr != '0) && !clr_busy;
        wr0_word = '0;
        wr1_word = '0;
        wr1_base = (wr0_en && (wr0_addr == wr1_addr)) ? wr0_word : mem[wr1_addr];
        for (int b = 0; b < NB; b++) begin
            wr0_word[b*8 +: 8] = byte_merge(mem[wr0_addr][b*8 +: 8], wr0_data[b*8 +: 8], wr0_be[b]);
        end
        if (wr0_en && (wr0_addr == wr1_addr)) begin
            wr1_base = wr0_word;
        end
        for (int b = 0; b < NB; b++) begin
            wr1_word[b*8 +: 8] = byte_merge(wr1_base[b*8 +: 8], wr1_data[b*8 +: 8], wr1_be[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_valid) begin
            mem[clr_idx] <= '0;
        end else begin
            if (wr0_en) begin
                mem[wr0_addr] <= wr0_word;
            end
            if (wr1_en) begin
                mem[wr1_addr] <= wr1_word;
            end
        end
    end

    always_comb begin
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] word;
        rd_data = '0;
        a       = '0;
        word    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a    = rd_addr[k*AW +: AW];
            word = mem[a];
`ifdef REGFILE_BYPASS_EN
            // wrX_en already excludes address 0 and the clear sweep.
            if (wr0_en && (wr0_addr == a)) begin
                for (int b = 0; b < NB; b++) begin
                    word[b*8 +: 8] = byte_merge(word[b*8 +: 8], wr0_data[b*8 +: 8], wr0_be[b]);
                end
            end
            if (wr1_en && (wr1_addr == a)) begin
                for (int b = 0; b < NB; b++) begin
                    word[b*8 +: 8] = byte_merge(word[b*8 +: 8], wr1_data[b*8 +: 8], wr1_be[b]);
                end
            end
`endif
            if (a == '0) begin
                word = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = word;
        end
    end

endmodule

// File: doc/regfile_mips_param.md
# regfile_mips_param

Parametrised multi-port MIPS general-purpose register file: the successor of the fixed 32x32, two-read/one-write byte-enabled register file. It adds configurable width, depth and read-port count, a second write port with defined conflict resolution, and a sequenced clear engine. The block sits in the decode stage, feeding operand reads and taking writeback from up to two retiring instructions per cycle.

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- DEPTH, 32: number of registers; power of two, at least 4.
- NUM_RD, 2: number of asynchronous read ports, 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]; AW = $clog2(DEPTH).
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
- wr0_addr / wr1_addr  in  AW  write addresses.
- wr0_data / wr1_data  in  DATA_W  write data.
- wr0_be / wr1_be  in  DATA_W/8  byte write enables; all-zero means no write.
- clr_req  in  1  single-cycle request to zero the whole file.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

## Operation
- Register 0 is hardwired zero. Writes to address 0 are discarded, and reads of address 0 return 0 on every port.
- Write: on the rising edge, each byte b with wrX_be[b]=1 updates byte b of register wrX_addr.
- Same address, same byte on both write ports: port 1 wins. Disjoint bytes of the same address merge.
- Read: rd_data for port k is a combinational function of rd_addr for port k and storage. Out-of-range addresses are impossible because DEPTH is a power of two.
- Clear FSM has two states.
  - IDLE: when clr_req=1, go to CLEAR and load idx=1.
  - CLEAR: zero register idx each cycle and increment idx. After idx = DEPTH-1 is zeroed, go to IDLE and pulse clr_done.
- While clr_busy=1:
  - Both write ports are ignored entirely.
  - clr_req is ignored.
  - Reads return current storage: partially cleared contents are visible.
- clr_req in the same cycle as writes while IDLE: those writes commit, and the sweep starts next cycle.

## Timing
- Reset values:
  - all registers 0
  - FSM IDLE, idx 0
  - clr_busy=0, clr_done=0
  - rd_data is whatever storage yields, which is 0 after reset.
- Reset asserted mid-sweep aborts it: state IDLE, and no clr_done pulse.
- Write-to-read latency is 1 cycle: data written at edge N is visible on rd_data after edge N, unless the bypass is compiled in (see Configuration).
- clr_req sampled at edge N:
  - clr_busy=1 from edge N through edge N+DEPTH-2.
  - clr_done=1 for the single cycle after edge N+DEPTH-1; clr_busy falls at the same edge.
  - Total sweep is DEPTH-1 cycles.
- clr_busy and clr_done are registered outputs.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose address matches an active same-cycle write returns that write's new bytes combinationally. Bytes without an enable come from storage, port 1 takes priority, and address 0 still reads 0. The bypass is suppressed while clr_busy=1.
- REGFILE_BYPASS_EN undefined: reads always return pre-edge storage, and the same-cycle write is seen on the next cycle.

## Structure
- Shared package regfile_pkg holds:
  - the clear FSM state enum (CLR_IDLE, CLR_SWEEP)
  - a function for the byte-merge of one write into a word, used by both storage update and bypass.
- One sub-module, regfile_clear_fsm, contains the state, the index counter and the busy/done outputs, and exposes a per-cycle clear index/valid to the storage array.
- Storage and the read muxes stay in the top module.

## Test plan
All scenarios use DATA_W=32, DEPTH=32, NUM_RD=2.
- Reset: drop rst_n, read addresses 0..31 -> all read 0x00000000; clr_busy=0; clr_done=0.
- Byte writes: wr0 addr 5, data 0xAABBCCDD, be 4'b0101, over prior 0 -> next cycle r5 reads 0x00BB00DD; write addr 0 with 0xFFFFFFFF, be 4'hF -> r0 still reads 0.
- Dual-write conflict: same cycle wr0(7, 0x11111111, 4'b0011) and wr1(7, 0x22222222, 4'b0110) -> r7 = 0x00222211.
- Bypass: write addr 9 = 0x12345678 while rd_addr port 0 = 9.
  - REGFILE_BYPASS_EN defined -> the same cycle reads 0x12345678.
  - REGFILE_BYPASS_EN undefined -> the same cycle reads the old value, and the next cycle reads 0x12345678.
- Clear sweep: fill r1..r31 with nonzero values, pulse clr_req.
  - clr_busy high for 31 cycles, then a single-cycle clr_done.
  - A write issued during the sweep is dropped.
  - A second clr_req issued during the sweep is ignored.
  - Afterwards all registers read 0.
- Reset mid-sweep: assert rst_n low at sweep cycle 10 -> all registers 0; clr_busy=0 immediately; no clr_done pulse.
